// File: rtl/bicubic_tap_sequencer.sv
// bicubic_tap_sequencer: walks the 16 bicubic neighbour taps of every
// destination pixel and presents one tap per valid/ready handshake.
// Source coordinates come from incremental Q.8 accumulators (no multiply).
module bicubic_tap_sequencer #(
  parameter int SHIFT_AMOUNT = 8,
  parameter int DIM_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DIM_W-1:0]        src_rows,
  input  logic [DIM_W-1:0]        src_cols,
  input  logic [DIM_W-1:0]        dst_rows,
  input  logic [DIM_W-1:0]        dst_cols,
  input  logic signed [31:0]      x_ratio,
  input  logic signed [31:0]      y_ratio,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIM_W-1:0]        out_i,
  output logic [DIM_W-1:0]        out_j,
  output logic signed [2:0]       out_m,
  output logic signed [2:0]       out_n,
  output logic signed [31:0]      out_x_old,
  output logic signed [31:0]      out_y_old,
  output logic [DIM_W-1:0]        out_src_x,
  output logic [DIM_W-1:0]        out_src_y,
  output logic signed [31:0]      out_dx,
  output logic signed [31:0]      out_dy,
  output logic                    out_last_tap,
  output logic                    out_last_pixel
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;

  state_t           r_state;
  logic [DIM_W-1:0] r_src_rows, r_src_cols, r_dst_rows, r_dst_cols;
  logic [31:0]      r_x_ratio, r_y_ratio;
  logic [31:0]      r_x_acc, r_y_acc;
  logic [1:0]       r_m_idx, r_n_idx;   // tap offset + 1, i.e. 0..3

  logic [DIM_W-1:0] w_cfg_src_rows, w_cfg_src_cols, w_cfg_dst_rows, w_cfg_dst_cols;
  logic [DIM_W-1:0] w_nx_i, w_nx_j;
  logic [1:0]       w_nx_m, w_nx_n;
  logic [31:0]      w_nx_x_acc, w_nx_y_acc;
  logic             w_accept, w_final, w_start_ok, w_load;

  // Anchor plus tap offset, clamped into [0, dim-1]; an empty dimension clamps to 0.
  function automatic logic [DIM_W-1:0] clamp_coord(input logic [31:0] acc,
                                                   input logic [1:0]  idx,
                                                   input logic [DIM_W-1:0] dim);
    logic signed [33:0] pos;
    logic signed [33:0] lim;
    pos = $signed({2'b00, acc >> SHIFT_AMOUNT}) + $signed({32'd0, idx}) - 34'sd1;
    lim = $signed({{(34-DIM_W){1'b0}}, dim}) - 34'sd1;
    if (dim == {DIM_W{1'b0}}) begin
      clamp_coord = {DIM_W{1'b0}};
    end else if (pos < 34'sd0) begin
      clamp_coord = {DIM_W{1'b0}};
    end else if (pos > lim) begin
      clamp_coord = dim - DIM_W'(1);
    end else begin
      clamp_coord = pos[DIM_W-1:0];
    end
  endfunction

  // Fractional part of the accumulator minus the tap offset, in Q.8.
  function automatic logic signed [31:0] frac_offset(input logic [31:0] acc,
                                                     input logic [1:0]  idx);
    logic [31:0]        frac;
    logic signed [31:0] tap;
    frac        = acc & ((32'd1 << SHIFT_AMOUNT) - 32'd1);
    tap         = $signed({30'd0, idx}) - 32'sd1;
    frac_offset = $signed(frac) - (tap <<< SHIFT_AMOUNT);
  endfunction

  assign w_accept   = out_valid && out_ready;
  assign w_final    = out_last_tap && out_last_pixel;
  assign w_start_ok = (dst_rows != {DIM_W{1'b0}}) && (dst_cols != {DIM_W{1'b0}});
  assign w_load     = ((r_state == ST_IDLE) && start && w_start_ok) ||
                      ((r_state == ST_RUN) && w_accept && !w_final);

  // Next tap position: first tap of a frame from IDLE, otherwise n, m, j, i odometer.
  always_comb begin
    w_cfg_src_rows = r_src_rows;
    w_cfg_src_cols = r_src_cols;
    w_cfg_dst_rows = r_dst_rows;
    w_cfg_dst_cols = r_dst_cols;
    w_nx_i         = out_i;
    w_nx_j         = out_j;
    w_nx_m         = r_m_idx;
    w_nx_n         = r_n_idx;
    w_nx_x_acc     = r_x_acc;
    w_nx_y_acc     = r_y_acc;
    if (r_state == ST_IDLE) begin
      w_cfg_src_rows = src_rows;
      w_cfg_src_cols = src_cols;
      w_cfg_dst_rows = dst_rows;
      w_cfg_dst_cols = dst_cols;
      w_nx_i         = {DIM_W{1'b0}};
      w_nx_j         = {DIM_W{1'b0}};
      w_nx_m         = 2'd0;
      w_nx_n         = 2'd0;
      w_nx_x_acc     = 32'd0;
      w_nx_y_acc     = 32'd0;
    end else if (r_n_idx != 2'd3) begin
      w_nx_n = r_n_idx + 2'd1;
    end else begin
      w_nx_n = 2'd0;
      if (r_m_idx != 2'd3) begin
        w_nx_m = r_m_idx + 2'd1;
      end else begin
        w_nx_m = 2'd0;
        if (out_j != r_dst_cols - DIM_W'(1)) begin
          w_nx_j     = out_j + DIM_W'(1);
          w_nx_x_acc = r_x_acc + r_x_ratio;
        end else begin
          w_nx_j     = {DIM_W{1'b0}};
          w_nx_x_acc = 32'd0;
          if (out_i != r_dst_rows - DIM_W'(1)) begin
            w_nx_i     = out_i + DIM_W'(1);
            w_nx_y_acc = r_y_acc + r_y_ratio;
          end else begin
            w_nx_i     = out_i;
            w_nx_y_acc = r_y_acc;
          end
        end
      end
    end
  end

  // Control FSM: frame sequencing, busy/valid/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && w_start_ok) begin
            r_state   <= ST_RUN;
            busy      <= 1'b1;
            out_valid <= 1'b1;
          end else if (start) begin
            r_state <= ST_FLUSH;
            done    <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_accept && w_final) begin
            r_state   <= ST_FLUSH;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_IDLE;
          done    <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: config latch on start and registered tap fields on every advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_rows <= {DIM_W{1'b0}};
      r_src_cols <= {DIM_W{1'b0}};
      r_dst_rows <= {DIM_W{1'b0}};
      r_dst_cols <= {DIM_W{1'b0}};
      r_x_ratio  <= 32'd0;
      r_y_ratio  <= 32'd0;
      r_x_acc    <= 32'd0;
      r_y_acc    <= 32'd0;
      r_m_idx    <= 2'd0;
      r_n_idx    <= 2'd0;
      out_i          <= {DIM_W{1'b0}};
      out_j          <= {DIM_W{1'b0}};
      out_m          <= 3'sd0;
      out_n          <= 3'sd0;
      out_x_old      <= 32'sd0;
      out_y_old      <= 32'sd0;
      out_src_x      <= {DIM_W{1'b0}};
      out_src_y      <= {DIM_W{1'b0}};
      out_dx         <= 32'sd0;
      out_dy         <= 32'sd0;
      out_last_tap   <= 1'b0;
      out_last_pixel <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_src_rows <= src_rows;
        r_src_cols <= src_cols;
        r_dst_rows <= dst_rows;
        r_dst_cols <= dst_cols;
        r_x_ratio  <= x_ratio;
        r_y_ratio  <= y_ratio;
      end
      if (w_load) begin
        r_x_acc        <= w_nx_x_acc;
        r_y_acc        <= w_nx_y_acc;
        r_m_idx        <= w_nx_m;
        r_n_idx        <= w_nx_n;
        out_i          <= w_nx_i;
        out_j          <= w_nx_j;
        out_m          <= 3'({1'b0, w_nx_m}) - 3'd1;
        out_n          <= 3'({1'b0, w_nx_n}) - 3'd1;
        out_x_old      <= $signed(w_nx_x_acc >> SHIFT_AMOUNT);
        out_y_old      <= $signed(w_nx_y_acc >> SHIFT_AMOUNT);
        out_src_x      <= clamp_coord(w_nx_x_acc, w_nx_n, w_cfg_src_cols);
        out_src_y      <= clamp_coord(w_nx_y_acc, w_nx_m, w_cfg_src_rows);
        out_dx         <= frac_offset(w_nx_x_acc, w_nx_n);
        out_dy         <= frac_offset(w_nx_y_acc, w_nx_m);
        out_last_tap   <= (w_nx_m == 2'd3) && (w_nx_n == 2'd3);
        out_last_pixel <= (w_nx_i == w_cfg_dst_rows - DIM_W'(1)) &&
                          (w_nx_j == w_cfg_dst_cols - DIM_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_bicubic_tap_sequencer.sv
// Scoreboard bench for bicubic_tap_sequencer: stimulus pushes expected taps,
// a monitor pops and compares on every accepted tap and checks stall stability.
module tb_bicubic_tap_sequencer;

  logic clk = 1'b0;
  logic rst_n, start, out_ready;
  logic [15:0] src_rows, src_cols, dst_rows, dst_cols;
  logic signed [31:0] x_ratio, y_ratio;
  logic busy, done, out_valid;
  logic [15:0] out_i, out_j, out_src_x, out_src_y;
  logic signed [2:0] out_m, out_n;
  logic signed [31:0] out_x_old, out_y_old, out_dx, out_dy;
  logic out_last_tap, out_last_pixel;

  always #5 clk = ~clk;

  bicubic_tap_sequencer #(.SHIFT_AMOUNT(8), .DIM_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_rows(src_rows), .src_cols(src_cols), .dst_rows(dst_rows), .dst_cols(dst_cols),
    .x_ratio(x_ratio), .y_ratio(y_ratio),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_i(out_i), .out_j(out_j), .out_m(out_m), .out_n(out_n),
    .out_x_old(out_x_old), .out_y_old(out_y_old),
    .out_src_x(out_src_x), .out_src_y(out_src_y),
    .out_dx(out_dx), .out_dy(out_dy),
    .out_last_tap(out_last_tap), .out_last_pixel(out_last_pixel)
  );

  typedef struct packed {
    logic [15:0] i, j;
    logic [2:0]  m, n;
    logic [31:0] x_old, y_old;
    logic [15:0] src_x, src_y;
    logic [31:0] dx, dy;
    logic        last_tap, last_pixel;
  } tap_t;

  tap_t exp_q[$];
  tap_t cap_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   mon_taps = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   ready_rand = 1'b0;

  task automatic check(input bit ok, input string name, input logic [199:0] act, input logic [199:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic tap_t cur_tap();
    return {out_i, out_j, out_m, out_n, out_x_old, out_y_old, out_src_x, out_src_y,
            out_dx, out_dy, out_last_tap, out_last_pixel};
  endfunction

  function automatic longint clampv(longint p, logic [15:0] dim);
    if (dim == 16'd0) return 0;
    if (p < 0) return 0;
    if (p > longint'(dim) - 1) return longint'(dim) - 1;
    return p;
  endfunction

  // Reference tap straight from j*x_ratio / i*y_ratio.
  function automatic tap_t model_tap(int i, int j, int m, int n, logic [15:0] sr, logic [15:0] sc,
                                     logic [15:0] dr, logic [15:0] dc, logic [31:0] xr, logic [31:0] yr);
    tap_t t;
    logic [31:0] xa, ya;
    longint xo, yo;
    xa = 32'(j) * xr;
    ya = 32'(i) * yr;
    xo = longint'(xa >> 8);
    yo = longint'(ya >> 8);
    t.i = 16'(i); t.j = 16'(j); t.m = 3'(m); t.n = 3'(n);
    t.x_old = 32'(xo); t.y_old = 32'(yo);
    t.src_x = 16'(clampv(xo + n, sc));
    t.src_y = 16'(clampv(yo + m, sr));
    t.dx = 32'(longint'(xa & 32'hFF) - n * 256);
    t.dy = 32'(longint'(ya & 32'hFF) - m * 256);
    t.last_tap = (m == 2) && (n == 2);
    t.last_pixel = (i == int'(dr) - 1) && (j == int'(dc) - 1);
    return t;
  endfunction

  task automatic push_frame(input logic [15:0] sr, sc, dr, dc, input logic [31:0] xr, yr);
    for (int i = 0; i < int'(dr); i++)
      for (int j = 0; j < int'(dc); j++)
        for (int m = -1; m <= 2; m++)
          for (int n = -1; n <= 2; n++)
            exp_q.push_back(model_tap(i, j, m, n, sr, sc, dr, dc, xr, yr));
  endtask

  // Pulse start for one cycle, then scramble the config inputs.
  task automatic start_frame(input logic [15:0] sr, sc, dr, dc, input logic [31:0] xr, yr);
    @(negedge clk);
    src_rows = sr; src_cols = sc; dst_rows = dr; dst_cols = dc; x_ratio = xr; y_ratio = yr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_rows = 16'd9; src_cols = 16'd11; dst_rows = 16'd2; dst_cols = 16'd1;
    x_ratio = 32'sh3F1; y_ratio = 32'sh77;
  endtask

  task automatic wait_done(input int limit);
    while (!done && cyc < limit) begin
      @(negedge clk); #2;
      cyc++;
    end
    check(done, "done_seen", 200'(done), 200'(1));
  endtask

  // Ready driver: always ready, or roughly two-thirds ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: compare every accepted tap against the scoreboard; check stall stability.
  initial begin
    tap_t e, held;
    bit   stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk); #1;
      if (!mon_en) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          check(out_valid && (cur_tap() == held), "stall_hold", cur_tap(), held);
        if (out_valid && out_ready) begin
          mon_taps++;
          cap_q.push_back(cur_tap());
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_tap", cur_tap(), '0);
          end else begin
            e = exp_q.pop_front();
            check(cur_tap() == e, "tap_stream", cur_tap(), e);
          end
        end
        stall_prev = out_valid && !out_ready;
        held = cur_tap();
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0;
    src_rows = 16'd0; src_cols = 16'd0; dst_rows = 16'd0; dst_cols = 16'd0;
    x_ratio = 32'sd0; y_ratio = 32'sd0;
    repeat (3) @(negedge clk);
    #2;
    check({busy, done, out_valid} == 3'b000, "reset_ctrl", 200'({busy, done, out_valid}), 200'(0));
    check(cur_tap() == '0, "reset_data", cur_tap(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Frame A: 4x4 -> 8x8, ratio 0x80, ready high, stray start mid-frame.
    mon_taps = 0; cap_q.delete();
    push_frame(16'd4, 16'd4, 16'd8, 16'd8, 32'h80, 32'h80);
    start_frame(16'd4, 16'd4, 16'd8, 16'd8, 32'h80, 32'h80);
    #2; cyc = 1;
    check(busy && out_valid, "start_latency", 200'({busy, out_valid}), 200'(3));
    repeat (200) begin @(negedge clk); #2; cyc++; end
    @(negedge clk);
    x_ratio = 32'sh40; dst_rows = 16'd2; dst_cols = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2; cyc += 2;
    wait_done(5000);
    check(cyc == 1025, "frame_cycles", 200'(cyc), 200'(1025));
    check(!busy && !out_valid, "idle_after_frame", 200'({busy, out_valid}), 200'(0));
    check(mon_taps == 1024, "tap_count_a", 200'(mon_taps), 200'(1024));
    check(exp_q.size() == 0, "queue_empty_a", 200'(exp_q.size()), 200'(0));
    @(negedge clk); #2;
    check(!done, "done_one_cycle", 200'(done), 200'(0));
    if (cap_q.size() == 1024) begin
      check(cap_q[144].x_old == 32'h0, "px11_x_old", 200'(cap_q[144].x_old), 200'(0));
      check(cap_q[144].dx == 32'h180, "px11_dx0", 200'(cap_q[144].dx), 200'(32'h180));
      check(cap_q[145].dx == 32'h080, "px11_dx1", 200'(cap_q[145].dx), 200'(32'h080));
      check(cap_q[146].dx == 32'hFFFF_FF80, "px11_dx2", 200'(cap_q[146].dx), 200'(32'hFFFF_FF80));
      check(cap_q[147].dx == 32'hFFFF_FE80, "px11_dx3", 200'(cap_q[147].dx), 200'(32'hFFFF_FE80));
      check(cap_q[0].src_x == 16'd0 && cap_q[0].n == 3'b111, "clamp_low", 200'(cap_q[0].src_x), 200'(0));
      check(cap_q[1023].src_x == 16'd3, "clamp_high", 200'(cap_q[1023].src_x), 200'(3));
      check(cap_q[1023].last_tap && cap_q[1023].last_pixel, "final_flags",
            200'({cap_q[1023].last_tap, cap_q[1023].last_pixel}), 200'(3));
      check(!cap_q[1019].last_tap && cap_q[1019].last_pixel, "flags_prev_tap",
            200'({cap_q[1019].last_tap, cap_q[1019].last_pixel}), 200'(1));
    end else begin
      check(1'b0, "capture_size", 200'(cap_q.size()), 200'(1024));
    end

    // Frame B: same frame with random backpressure.
    ready_rand = 1'b1;
    mon_taps = 0; cap_q.delete();
    push_frame(16'd4, 16'd4, 16'd8, 16'd8, 32'h80, 32'h80);
    start_frame(16'd4, 16'd4, 16'd8, 16'd8, 32'h80, 32'h80);
    #2; cyc = 1;
    wait_done(20000);
    check(mon_taps == 1024, "tap_count_b", 200'(mon_taps), 200'(1024));
    check(exp_q.size() == 0, "queue_empty_b", 200'(exp_q.size()), 200'(0));
    ready_rand = 1'b0;

    // Zero-dimension frame.
    start_frame(16'd4, 16'd4, 16'd8, 16'd0, 32'h80, 32'h80);
    #2;
    check(done && !busy && !out_valid, "zero_dim_done", 200'({done, busy, out_valid}), 200'(4));
    @(negedge clk); #2;
    check(!done && !busy && !out_valid, "zero_dim_after", 200'({done, busy, out_valid}), 200'(0));

    // Reset after 37 taps, then restart on a different frame.
    mon_taps = 0; cap_q.delete();
    push_frame(16'd4, 16'd4, 16'd8, 16'd8, 32'h80, 32'h80);
    start_frame(16'd4, 16'd4, 16'd8, 16'd8, 32'h80, 32'h80);
    #2; cyc = 1;
    while (mon_taps < 37 && cyc < 200) begin @(negedge clk); #2; cyc++; end
    check(mon_taps == 37, "reach_tap37", 200'(mon_taps), 200'(37));
    @(posedge clk); #1;
    mon_en = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check({busy, done, out_valid} == 3'b000, "midreset_ctrl", 200'({busy, done, out_valid}), 200'(0));
    check(cur_tap() == '0, "midreset_data", cur_tap(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check(!busy && !out_valid && !done, "idle_after_reset", 200'({busy, out_valid, done}), 200'(0));
    mon_en = 1'b1; mon_taps = 0; cap_q.delete();
    push_frame(16'd3, 16'd5, 16'd2, 16'd3, 32'h1AA, 32'h180);
    start_frame(16'd3, 16'd5, 16'd2, 16'd3, 32'h1AA, 32'h180);
    #2; cyc = 1;
    check(out_valid && out_i == 16'd0 && out_j == 16'd0 && out_m == -3'sd1 && out_n == -3'sd1,
          "restart_first_tap", cur_tap(), '0);
    wait_done(500);
    check(mon_taps == 96, "tap_count_c", 200'(mon_taps), 200'(96));
    check(exp_q.size() == 0, "queue_empty_c", 200'(exp_q.size()), 200'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bicubic_tap_sequencer.md
# bicubic_tap_sequencer

Initiator side of the bicubic weight interface in the resize datapath. For every destination pixel (i,j) it walks the 16 neighbour taps (m,n ∈ {-1,0,1,2}) and emits one tap per handshake. Each tap carries the source anchor (x_old, y_old), the clamped source address and the signed Q.8 offsets dx/dy consumed by the R-value/weight logic. It uses incremental accumulators, with no per-pixel multiply, and sits between the host-programmed resize registers and the pixel fetch / MAC stage.

## Interface
- SHIFT_AMOUNT, 8, fractional bits of ratios and offsets (Q.8)
- DIM_W, 16, width of dimension and coordinate fields
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches config and begins a frame (ignored while busy)
- src_rows, src_cols  in  DIM_W  source image size
- dst_rows, dst_cols  in  DIM_W  destination image size
- x_ratio, y_ratio  in  32 signed  Q.8 step per destination column/row (src/dst scaled by 2^SHIFT_AMOUNT)
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the final tap is accepted
- out_valid  out  1  tap valid
- out_ready  in  1  consumer accepts tap
- out_i, out_j  out  DIM_W  destination row/col
- out_m, out_n  out  3 signed  tap offset, -1..2
- out_x_old, out_y_old  out  32 signed  integer source anchor
- out_src_x, out_src_y  out  DIM_W  anchor+offset clamped to [0, src_cols-1] / [0, src_rows-1]
- out_dx, out_dy  out  32 signed  Q.8 offset: (j·x_ratio − (x_old<<8)) − (n<<8), same for y with m
- out_last_tap  out  1  tap is (m,n)=(2,2)
- out_last_pixel  out  1  tap belongs to pixel (dst_rows-1, dst_cols-1)

## Operation
- States: IDLE, RUN, FLUSH.
  - IDLE→RUN on start when dst_rows≠0 and dst_cols≠0.
  - IDLE→FLUSH on start with a zero dimension. FLUSH pulses done and returns to IDLE with no taps emitted.
  - RUN→FLUSH when the tap with out_last_tap && out_last_pixel is accepted.
- Config is latched at start. Changes to the input config during RUN have no effect.
- Iteration order, outermost first: i 0..dst_rows-1, j 0..dst_cols-1, m -1..2, n -1..2.
- Accumulators, unsigned 32-bit, wrap is not guarded:
  - x_acc = j·x_ratio. Cleared at the start of each row; x_ratio is added when j advances.
  - y_acc = i·y_ratio. Cleared at frame start; y_ratio is added when i advances.
- x_old = x_acc>>SHIFT_AMOUNT and fx = x_acc[7:0]. dx = fx − (n<<8), giving fx+256, fx, fx−256 or fx−512. y/dy use the same rules.
- Clamp: if x_old+n<0 then 0. If x_old+n>src_cols-1 then src_cols-1. src_cols=0 clamps to 0. Rows follow the same rules.
- Handshake: a transfer occurs when out_valid && out_ready. While out_valid && !out_ready, all out_* fields are held stable. out_valid never drops without a transfer.
- A start pulse during busy is ignored.
- rst_n low at any time, including mid-frame: immediately returns to IDLE, and all outputs go to 0.

## Timing
- Reset values: busy=0, done=0, out_valid=0, and every data output 0.
- start accepted at edge t: busy=1 and out_valid=1 with tap (0,0,-1,-1) from t+1.
- Throughput: one tap per cycle under continuous out_ready. A frame takes 16·dst_rows·dst_cols cycles.
- All outputs are registered. No combinational path exists from out_ready to out_valid or to the data outputs.
- Final acceptance at edge t: out_valid=0 and busy=0 at t+1, done=1 for t+1 only.
- Zero-dimension frame: done pulses at t+1 after start, and busy is never asserted.

## Test plan
- 4×4→8×8, ratio 0x80, ready held high:
  - exactly 1024 taps, then done.
  - pixel (1,1): x_old=0, fx=0x80; dx sequence 0x180, 0x080, −0x080, −0x180.
- Same frame with out_ready toggled pseudo-randomly:
  - identical tap stream.
  - outputs stable throughout every stall.
- Clamp: pixel (0,0) with n=-1 → out_src_x=0. Last pixel with n=2 → out_src_x=3.
- dst_cols=0 → done at the cycle after start, no out_valid, busy stays 0.
- rst_n low for one cycle after tap 37:
  - all outputs 0 and the block is in IDLE.
  - a new start yields tap (0,0,-1,-1).
- start pulsed mid-frame → ignored; tap count is still 1024. out_last_tap/out_last_pixel flags are correct on the final tap.
